// File: rtl/pusch_pkg.sv
// Shared constants and read-FSM state type for the PUSCH ping-pong buffer.
package pusch_pkg;

  localparam int PUSCH_MAX_SC = 1200;
  localparam int PUSCH_FFT_W  = 18;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_STREAM = 2'd1,
    RD_DRAIN  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/pusch_pp_bank.sv
// One ping-pong bank: simple dual-port RAM, one write port, one synchronous read port.
module pusch_pp_bank #(
  parameter int DEPTH = 1200,
  parameter int WIDTH = 36,
  parameter int AW    = 11
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;

  // Write port and registered read port; read data holds when no read is issued.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_q <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/pusch_pingpong_buf.sv
// N-lane ping-pong sample buffer between modulation mapper and transform-precoding FFT.
// Write side fills one bank while the read side streams the other.
//
// state     | meaning
// RD_IDLE   | nothing outstanding; waits for the read bank to be committed
// RD_STREAM | issuing RAM reads of the read bank
// RD_DRAIN  | read bank fully issued; waiting for its last handshake, may prefetch the other bank
module pusch_pingpong_buf
  import pusch_pkg::*;
#(
  parameter int DATA_WIDTH = PUSCH_FFT_W,
  parameter int NUM_CH     = 2,
  parameter int MEM_DEPTH  = PUSCH_MAX_SC,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_wr_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_wr_data,
  input  logic                         i_wr_last,
  output logic                         o_wr_ready,
  output logic                         o_rd_valid,
  input  logic                         i_rd_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_rd_data,
  output logic                         o_rd_last,
  output logic [ADDR_WIDTH-1:0]        o_rd_idx,
  output logic [1:0]                   o_bank_full,
  output logic                         o_err_ovf
);

  localparam int DW = NUM_CH * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE = (ADDR_WIDTH+1)'(1);

  // write side
  logic                  r_wr_bank;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_len [2];
  logic [1:0]            r_bank_full;
  logic                  r_err_ovf;
  logic                  w_wr_ready, w_wr_acc, w_commit, w_release;

  // read side
  rd_state_e             r_state, w_state_nxt;
  logic                  r_rd_bank, r_iss_bank, w_iss_bank_nxt;
  logic [ADDR_WIDTH-1:0] r_iss_ptr, w_iss_ptr_nxt;
  logic                  r_pend_v, r_pend_bank, r_pend_last;
  logic [ADDR_WIDTH-1:0] r_pend_idx;
  logic                  r_out_v, r_out_last, r_skid_v, r_skid_last;
  logic [DW-1:0]         r_out_data, r_skid_data;
  logic [ADDR_WIDTH-1:0] r_out_idx, r_skid_idx;
  logic                  w_pop, w_room, w_iss_ok, w_issue, w_iss_last;
  logic [1:0]            w_occ;
  logic [DW-1:0]         w_q0, w_q1, w_ram_q;

  assign w_wr_ready = ~r_bank_full[r_wr_bank];
  assign w_wr_acc   = i_enable & i_wr_valid & w_wr_ready;
  assign w_commit   = w_wr_acc & (i_wr_last | (r_wr_ptr == PTR_MAX));

  // Write pointer, commit, bank-full bookkeeping and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_bank   <= 1'b0;
      r_wr_ptr    <= '0;
      r_len[0]    <= '0;
      r_len[1]    <= '0;
      r_bank_full <= 2'b00;
      r_err_ovf   <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        if (w_commit) begin
          r_len[r_wr_bank] <= {1'b0, r_wr_ptr} + LEN_ONE;
          r_wr_bank        <= ~r_wr_bank;
          r_wr_ptr         <= '0;
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
      end
      if (i_enable & i_wr_valid & ~w_wr_ready) r_err_ovf <= 1'b1;
      // commit and release always target different banks, so both may land in one cycle
      for (int b = 0; b < 2; b++) begin
        if (w_commit && (r_wr_bank == 1'(b)))       r_bank_full[b] <= 1'b1;
        else if (w_release && (r_rd_bank == 1'(b))) r_bank_full[b] <= 1'b0;
      end
    end
  end

  // Occupancy counts the in-flight RAM read, which lands next edge; keep it within the two output slots.
  assign w_pop      = i_enable & r_out_v & i_rd_ready;
  assign w_occ      = 2'(r_out_v) + 2'(r_skid_v) + 2'(r_pend_v) - 2'(w_pop);
  assign w_room     = (w_occ <= 2'd1);
  assign w_iss_ok   = r_bank_full[r_iss_bank] & ((r_state != RD_DRAIN) | (r_iss_bank != r_rd_bank));
  assign w_issue    = i_enable & w_room & w_iss_ok;
  assign w_iss_last = ({1'b0, r_iss_ptr} == (r_len[r_iss_bank] - LEN_ONE));
  assign w_release  = (r_state == RD_DRAIN) & w_pop & r_out_last;

  // Next issue position and next FSM state.
  always_comb begin
    w_iss_bank_nxt = r_iss_bank;
    w_iss_ptr_nxt  = r_iss_ptr;
    w_state_nxt    = r_state;
    if (w_issue) begin
      if (w_iss_last) begin
        w_iss_bank_nxt = ~r_iss_bank;
        w_iss_ptr_nxt  = '0;
      end else begin
        w_iss_ptr_nxt = r_iss_ptr + 1'b1;
      end
    end
    case (r_state)
      RD_IDLE, RD_STREAM: begin
        if (w_issue) w_state_nxt = w_iss_last ? RD_DRAIN : RD_STREAM;
      end
      RD_DRAIN: begin
        if (w_release) begin
          // issue side already wrapped back: the next bank is fully issued too
          if (w_iss_bank_nxt == r_rd_bank)     w_state_nxt = RD_DRAIN;
          else if (r_bank_full[~r_rd_bank])    w_state_nxt = RD_STREAM;
          else                                 w_state_nxt = RD_IDLE;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM, issue pointer and the in-flight RAM read tag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= RD_IDLE;
      r_rd_bank   <= 1'b0;
      r_iss_bank  <= 1'b0;
      r_iss_ptr   <= '0;
      r_pend_v    <= 1'b0;
      r_pend_bank <= 1'b0;
      r_pend_idx  <= '0;
      r_pend_last <= 1'b0;
    end else if (i_enable) begin
      r_state    <= w_state_nxt;
      r_iss_bank <= w_iss_bank_nxt;
      r_iss_ptr  <= w_iss_ptr_nxt;
      if (w_release) r_rd_bank <= ~r_rd_bank;
      r_pend_v <= w_issue;
      if (w_issue) begin
        r_pend_bank <= r_iss_bank;
        r_pend_idx  <= r_iss_ptr;
        r_pend_last <= w_iss_last;
      end
    end
  end

  assign w_ram_q = r_pend_bank ? w_q1 : w_q0;

  // Two-entry output skid: out slot feeds the consumer, skid slot absorbs the read in flight at a stall.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_v     <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_skid_v    <= 1'b0;
      r_skid_data <= '0;
      r_skid_idx  <= '0;
      r_skid_last <= 1'b0;
    end else if (i_enable) begin
      if (w_pop) begin
        if (r_skid_v) begin
          r_out_data <= r_skid_data;
          r_out_idx  <= r_skid_idx;
          r_out_last <= r_skid_last;
          r_skid_v   <= r_pend_v;
          if (r_pend_v) begin
            r_skid_data <= w_ram_q;
            r_skid_idx  <= r_pend_idx;
            r_skid_last <= r_pend_last;
          end
        end else begin
          r_out_v <= r_pend_v;
          if (r_pend_v) begin
            r_out_data <= w_ram_q;
            r_out_idx  <= r_pend_idx;
            r_out_last <= r_pend_last;
          end
        end
      end else if (r_out_v) begin
        if (r_pend_v) begin
          r_skid_v    <= 1'b1;
          r_skid_data <= w_ram_q;
          r_skid_idx  <= r_pend_idx;
          r_skid_last <= r_pend_last;
        end
      end else if (r_pend_v) begin
        r_out_v    <= 1'b1;
        r_out_data <= w_ram_q;
        r_out_idx  <= r_pend_idx;
        r_out_last <= r_pend_last;
      end
    end
  end

  pusch_pp_bank #(.DEPTH(MEM_DEPTH), .WIDTH(DW), .AW(ADDR_WIDTH)) u_bank0 (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_acc & ~r_wr_bank),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_wr_data),
    .i_rd_en   (w_issue & ~r_iss_bank),
    .i_rd_addr (r_iss_ptr),
    .o_rd_data (w_q0)
  );

  pusch_pp_bank #(.DEPTH(MEM_DEPTH), .WIDTH(DW), .AW(ADDR_WIDTH)) u_bank1 (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_acc & r_wr_bank),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_wr_data),
    .i_rd_en   (w_issue & r_iss_bank),
    .i_rd_addr (r_iss_ptr),
    .o_rd_data (w_q1)
  );

  assign o_wr_ready  = w_wr_ready;
  assign o_rd_valid  = r_out_v;
  assign o_rd_data   = r_out_data;
  assign o_rd_last   = r_out_last;
  assign o_rd_idx    = r_out_idx;
  assign o_bank_full = r_bank_full;
  assign o_err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_pusch_pingpong_buf.sv
// Self-checking bench for pusch_pingpong_buf: scoreboard of expected beats vs monitored handshakes.
module tb_pusch_pingpong_buf;

  localparam int DW = 18;
  localparam int NC = 2;
  localparam int AW = 11;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_enable = 1'b1;
  logic              i_wr_valid = 1'b0;
  logic [NC*DW-1:0]  i_wr_data = '0;
  logic              i_wr_last = 1'b0;
  logic              o_wr_ready;
  logic              o_rd_valid;
  logic              i_rd_ready = 1'b0;
  logic [NC*DW-1:0]  o_rd_data;
  logic              o_rd_last;
  logic [AW-1:0]     o_rd_idx;
  logic [1:0]        o_bank_full;
  logic              o_err_ovf;

  pusch_pingpong_buf #(.DATA_WIDTH(DW), .NUM_CH(NC), .MEM_DEPTH(1200), .ADDR_WIDTH(AW)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_wr_valid  (i_wr_valid),
    .i_wr_data   (i_wr_data),
    .i_wr_last   (i_wr_last),
    .o_wr_ready  (o_wr_ready),
    .o_rd_valid  (o_rd_valid),
    .i_rd_ready  (i_rd_ready),
    .o_rd_data   (o_rd_data),
    .o_rd_last   (o_rd_last),
    .o_rd_idx    (o_rd_idx),
    .o_bank_full (o_bank_full),
    .o_err_ovf   (o_err_ovf)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [NC*DW-1:0] data;
    logic [AW-1:0]    idx;
    logic             last;
    int               cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // monitor: record every accepted output beat
  always @(negedge i_clk) begin
    if (!i_reset && i_enable && o_rd_valid && i_rd_ready)
      obs_q.push_back('{data: o_rd_data, idx: o_rd_idx, last: o_rd_last, cyc: cyc});
  end

  function automatic logic [NC*DW-1:0] mk_data(input int v);
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    a = DW'(v);
    b = DW'(-v);
    return {b, a};
  endfunction

  // all tasks enter and leave at posedge+1
  task automatic tb_reset();
    i_reset = 1'b1;
    i_wr_valid = 1'b0;
    i_wr_last = 1'b0;
    i_rd_ready = 1'b0;
    repeat (2) begin @(posedge i_clk); #1; end
    i_reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic write_sym(input int n, input int base, input bit use_last, input bit push);
    for (int i = 0; i < n; i++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = mk_data(base + i);
      i_wr_last  = use_last && (i == n - 1);
      if (push) exp_q.push_back('{data: mk_data(base + i), idx: AW'(i), last: (i == n - 1), cyc: 0});
      @(posedge i_clk); #1;
    end
    i_wr_valid = 1'b0;
    i_wr_last  = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int c = 0; c < budget && obs_q.size() < n; c++) begin @(posedge i_clk); #1; end
    repeat (4) begin @(posedge i_clk); #1; end
  endtask

  task automatic test_reset();
    tb_reset();
    n_total++; if (o_wr_ready !== 1'b1) $display("FAIL rst_wr_ready: got %b want 1", o_wr_ready); else n_pass++;
    n_total++; if (o_rd_valid !== 1'b0) $display("FAIL rst_rd_valid: got %b want 0", o_rd_valid); else n_pass++;
    n_total++; if (o_rd_last !== 1'b0) $display("FAIL rst_rd_last: got %b want 0", o_rd_last); else n_pass++;
    n_total++; if (o_rd_idx !== '0) $display("FAIL rst_rd_idx: got %0d want 0", o_rd_idx); else n_pass++;
    n_total++; if (o_rd_data !== '0) $display("FAIL rst_rd_data: got %h want 0", o_rd_data); else n_pass++;
    n_total++; if (o_bank_full !== 2'b00) $display("FAIL rst_bank_full: got %b want 00", o_bank_full); else n_pass++;
    n_total++; if (o_err_ovf !== 1'b0) $display("FAIL rst_err_ovf: got %b want 0", o_err_ovf); else n_pass++;
  endtask

  task automatic test_basic();
    int commit_cyc;
    beat_t e, o;
    tb_reset();
    i_rd_ready = 1'b1;
    write_sym(12, 0, 1'b1, 1'b1);
    commit_cyc = cyc;
    wait_beats(12, 40);
    n_total++; if (obs_q.size() != 12) $display("FAIL basic_count: got %0d want 12", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0) begin
      n_total++;
      if (obs_q[0].cyc != commit_cyc + 2) $display("FAIL basic_latency: got %0d want %0d", obs_q[0].cyc - commit_cyc, 2);
      else n_pass++;
    end
    if (obs_q.size() == 12) begin
      n_total++;
      if (obs_q[11].cyc != obs_q[0].cyc + 11) $display("FAIL basic_bubble: span got %0d want 11", obs_q[11].cyc - obs_q[0].cyc);
      else n_pass++;
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++;
      if (o.data !== e.data || o.idx !== e.idx || o.last !== e.last)
        $display("FAIL basic_beat%0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b", e.idx, o.data, o.idx, o.last, e.data, e.idx, e.last);
      else n_pass++;
    end
    n_total++; if (o_bank_full !== 2'b00) $display("FAIL basic_release: got %b want 00", o_bank_full); else n_pass++;
  endtask

  task automatic test_forced_commit();
    int errs;
    beat_t e, o;
    tb_reset();
    write_sym(1200, 0, 1'b0, 1'b1);
    n_total++; if (o_bank_full !== 2'b01) $display("FAIL forced_full: got %b want 01", o_bank_full); else n_pass++;
    n_total++; if (o_wr_ready !== 1'b1) $display("FAIL forced_wr_ready: got %b want 1", o_wr_ready); else n_pass++;
    write_sym(1, 3000, 1'b1, 1'b1);
    n_total++; if (o_bank_full !== 2'b11) $display("FAIL forced_bank1: got %b want 11", o_bank_full); else n_pass++;
    i_rd_ready = 1'b1;
    wait_beats(1201, 1400);
    n_total++; if (obs_q.size() != 1201) $display("FAIL forced_count: got %0d want 1201", obs_q.size()); else n_pass++;
    errs = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++;
      if (o.data !== e.data || o.idx !== e.idx || o.last !== e.last) begin
        if (errs < 5) $display("FAIL forced_beat: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b", o.data, o.idx, o.last, e.data, e.idx, e.last);
        errs++;
      end else n_pass++;
    end
  endtask

  task automatic test_overflow();
    beat_t e, o;
    tb_reset();
    n_total++; if (o_wr_ready !== 1'b1) $display("FAIL ovf_ready0: got %b want 1", o_wr_ready); else n_pass++;
    write_sym(24, 100, 1'b1, 1'b1);
    write_sym(24, 200, 1'b1, 1'b1);
    n_total++; if (o_wr_ready !== 1'b0) $display("FAIL ovf_ready_drop: got %b want 0", o_wr_ready); else n_pass++;
    n_total++; if (o_err_ovf !== 1'b0) $display("FAIL ovf_early: got %b want 0", o_err_ovf); else n_pass++;
    write_sym(1, 300, 1'b0, 1'b0);
    n_total++; if (o_err_ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", o_err_ovf); else n_pass++;
    write_sym(23, 301, 1'b1, 1'b0);
    i_rd_ready = 1'b1;
    wait_beats(48, 100);
    n_total++; if (obs_q.size() != 48) $display("FAIL ovf_count: got %0d want 48", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++;
      if (o.data !== e.data || o.idx !== e.idx || o.last !== e.last)
        $display("FAIL ovf_beat: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b", o.data, o.idx, o.last, e.data, e.idx, e.last);
      else n_pass++;
    end
    n_total++; if (o_err_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", o_err_ovf); else n_pass++;
  endtask

  task automatic test_stall();
    bit stall;
    logic [NC*DW-1:0] h_data;
    logic [AW-1:0] h_idx;
    beat_t e, o;
    tb_reset();
    write_sym(24, 400, 1'b1, 1'b1);
    stall = 1'b0;
    h_data = '0;
    h_idx = '0;
    for (int c = 0; c < 200 && obs_q.size() < 24; c++) begin
      i_rd_ready = ~i_rd_ready;
      @(negedge i_clk);
      if (stall) begin
        n_total++;
        if (o_rd_valid !== 1'b1 || o_rd_data !== h_data || o_rd_idx !== h_idx)
          $display("FAIL stall_hold: got v=%b data=%h idx=%0d want v=1 data=%h idx=%0d", o_rd_valid, o_rd_data, o_rd_idx, h_data, h_idx);
        else n_pass++;
      end
      stall = o_rd_valid && !i_rd_ready;
      h_data = o_rd_data;
      h_idx = o_rd_idx;
      @(posedge i_clk); #1;
    end
    i_rd_ready = 1'b1;
    wait_beats(24, 10);
    n_total++; if (obs_q.size() != 24) $display("FAIL stall_count: got %0d want 24", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++;
      if (o.data !== e.data || o.idx !== e.idx || o.last !== e.last)
        $display("FAIL stall_beat: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b", o.data, o.idx, o.last, e.data, e.idx, e.last);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    beat_t e, o;
    tb_reset();
    write_sym(16, 500, 1'b1, 1'b1);
    write_sym(10, 600, 1'b1, 1'b1);
    n_total++; if (o_bank_full !== 2'b11) $display("FAIL b2b_full: got %b want 11", o_bank_full); else n_pass++;
    i_rd_ready = 1'b1;
    wait_beats(26, 80);
    n_total++; if (obs_q.size() != 26) $display("FAIL b2b_count: got %0d want 26", obs_q.size()); else n_pass++;
    if (obs_q.size() == 26) begin
      n_total++;
      if (obs_q[16].cyc != obs_q[15].cyc + 1 || obs_q[15].last !== 1'b1 || obs_q[16].idx !== '0)
        $display("FAIL b2b_nobubble: got gap=%0d last15=%b idx16=%0d want gap=1 last15=1 idx16=0", obs_q[16].cyc - obs_q[15].cyc, obs_q[15].last, obs_q[16].idx);
      else n_pass++;
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++;
      if (o.data !== e.data || o.idx !== e.idx || o.last !== e.last)
        $display("FAIL b2b_beat: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b", o.data, o.idx, o.last, e.data, e.idx, e.last);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    beat_t e, o;
    tb_reset();
    write_sym(8, 700, 1'b1, 1'b0);
    write_sym(5, 800, 1'b0, 1'b0);
    i_wr_valid = 1'b1;
    i_wr_data  = mk_data(805);
    i_reset    = 1'b1;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_wr_valid = 1'b0;
    i_reset    = 1'b0;
    n_total++;
    if (o_wr_ready !== 1'b1 || o_rd_valid !== 1'b0 || o_rd_last !== 1'b0 || o_rd_idx !== '0 ||
        o_rd_data !== '0 || o_bank_full !== 2'b00 || o_err_ovf !== 1'b0)
      $display("FAIL midrst_outputs: got rdy=%b v=%b last=%b idx=%0d data=%h full=%b ovf=%b want 1 0 0 0 0 00 0",
               o_wr_ready, o_rd_valid, o_rd_last, o_rd_idx, o_rd_data, o_bank_full, o_err_ovf);
    else n_pass++;
    exp_q.delete();
    obs_q.delete();
    write_sym(4, 900, 1'b1, 1'b1);
    n_total++; if (o_bank_full !== 2'b01) $display("FAIL midrst_bank0: got %b want 01", o_bank_full); else n_pass++;
    i_rd_ready = 1'b1;
    wait_beats(4, 20);
    n_total++; if (obs_q.size() != 4) $display("FAIL midrst_count: got %0d want 4", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++;
      if (o.data !== e.data || o.idx !== e.idx || o.last !== e.last)
        $display("FAIL midrst_beat: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b", o.data, o.idx, o.last, e.data, e.idx, e.last);
      else n_pass++;
    end
  endtask

  initial begin
    @(posedge i_clk); #1;
    test_reset();
    test_basic();
    test_forced_commit();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
